// File: rtl/qr_r_collector.sv
// rtl/qr_r_collector.sv - collects R rows bottom-first from the QR core and drains them top-first
module qr_r_collector #(
  parameter int DATA_WIDTH = 20,
  parameter int D_WIDTH    = 4,
  parameter int ROWS       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [DATA_WIDTH*D_WIDTH-1:0] r_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [DATA_WIDTH*D_WIDTH-1:0] row_o,
  output logic [$clog2(ROWS)-1:0]       row_idx_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int RW = DATA_WIDTH * D_WIDTH;
  localparam int IW = $clog2(ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] wcnt_q, wcnt_d;
  logic [IW-1:0] rptr_q, rptr_d;
  logic          ovf_q;
  logic [RW-1:0] buf_q [ROWS];

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          ovf_set;
  logic          xfer;

  assign xfer = (state_q == DRAIN) && ready_i;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rptr_d  = rptr_q;
    wr_en   = 1'b0;
    wr_idx  = LAST_IDX;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          wr_en   = 1'b1;
          wcnt_d  = IW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (valid_i) begin
          wr_en  = 1'b1;
          wr_idx = LAST_IDX - wcnt_q;
          if (wcnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            rptr_d  = '0;
            state_d = DRAIN;
          end else begin
            wcnt_d = wcnt_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (xfer && rptr_q == LAST_IDX) begin
          // Final transfer frees the buffer, so a row arriving now starts the next matrix
          rptr_d = '0;
          if (valid_i) begin
            wr_en   = 1'b1;
            wcnt_d  = IW'(1);
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) rptr_d = rptr_q + IW'(1);
          ovf_set = valid_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < ROWS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rptr_q  <= rptr_d;
      if (ovf_set) ovf_q <= 1'b1;
      if (wr_en) buf_q[wr_idx] <= r_i;
    end
  end

  assign valid_o    = (state_q == DRAIN);
  assign row_o      = buf_q[rptr_q];
  assign row_idx_o  = rptr_q;
  assign last_o     = valid_o && (rptr_q == LAST_IDX);
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = ovf_q;

endmodule
